// File: rtl/em_updown_counter.sv
// em_updown_counter: parametrised synchronous up/down counter, modulus MODULUS, cascadable via rco/ent.
// Latency: q/wrap update on the rising edge after the inputs are sampled; tc/rco are combinational.
// Flow control: none; ent & enp gate counting, load and clr override. Optional macro EM_COUNTER_SAT_EN saturates instead of wrapping.
module em_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rco,
  output logic             wrap
);

  // Top count value, and the modulus extended by one bit so 2^WIDTH stays representable.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("em_updown_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("em_updown_counter: MODULUS must be 2..2^WIDTH");
  end

  logic             at_max;
  logic             at_zero;
  logic             count_en;
  logic             d_in_range;
  logic [WIDTH-1:0] q_up;
  logic [WIDTH-1:0] q_dn;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             limit_hit;

  // Limit detection and enable decode shared by the count path and the terminal-count outputs.
  always_comb begin
    at_max     = (q == MAX_Q);
    at_zero    = (q == '0);
    count_en   = ent & enp;
    d_in_range = ({1'b0, d} < MOD_EXT);
  end

  // Candidate next values in each direction; the modulus compare decides the wrap, even at 2^WIDTH.
  always_comb begin
    q_up = q + WIDTH'(1);
    q_dn = q - WIDTH'(1);
`ifdef EM_COUNTER_SAT_EN
    if (at_max)  q_up = MAX_Q;
    if (at_zero) q_dn = '0;
`else
    if (at_max)  q_up = '0;
    if (at_zero) q_dn = MAX_Q;
`endif
    limit_hit = up ? at_max : at_zero;
  end

  // Next-state selection in priority order load > count > hold (clr is applied in the register).
  always_comb begin
    q_nxt    = q;
    wrap_nxt = wrap;
    if (load) begin
      q_nxt    = d_in_range ? d : MAX_Q;
      wrap_nxt = 1'b0;
    end else if (count_en) begin
      q_nxt = up ? q_up : q_dn;
      if (limit_hit) begin
        wrap_nxt = 1'b1;
      end
    end
  end

  // State register with synchronous clear taking precedence over everything else.
  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Terminal count follows the current direction immediately; rco is gated only by ent for cascading.
  always_comb begin
    tc  = limit_hit;
    rco = limit_hit & ent;
  end

endmodule

// File: tb/tb_em_updown_counter.sv
// tb_em_updown_counter: self-checking bench for em_updown_counter (decade instance plus a two-stage binary cascade).
// Expected results are queued when stimulus is driven and popped after the clock edge.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_em_updown_counter;

  typedef struct {
    logic [3:0] q;
    logic       wrap;
    logic       tc;
    logic       rco;
  } exp_t;

  typedef struct {
    logic [7:0] q;
    logic       wrap_lo;
    logic       wrap_hi;
  } cexp_t;

  exp_t  sb[$];
  cexp_t csb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic       clk = 1'b0;
  logic       clr, load, ent, enp, up;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, rco, wrap;

  logic       c_clr, c_load, c_ent, c_enp, c_up;
  logic [3:0] c_d_lo, c_d_hi;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, rco_lo, wrap_lo, tc_hi, rco_hi, wrap_hi;

  always #5 clk = ~clk;

  em_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk(clk), .clr(clr), .load(load), .ent(ent), .enp(enp), .up(up),
    .d(d), .q(q), .tc(tc), .rco(rco), .wrap(wrap)
  );

  em_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clk(clk), .clr(c_clr), .load(c_load), .ent(c_ent), .enp(c_enp), .up(c_up),
    .d(c_d_lo), .q(q_lo), .tc(tc_lo), .rco(rco_lo), .wrap(wrap_lo)
  );

  em_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clk(clk), .clr(c_clr), .load(c_load), .ent(rco_lo), .enp(c_enp), .up(c_up),
    .d(c_d_hi), .q(q_hi), .tc(tc_hi), .rco(rco_hi), .wrap(wrap_hi)
  );

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] eq, input logic ew, input logic et, input logic er);
    exp_t e;
    e.q = eq; e.wrap = ew; e.tc = et; e.rco = er;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    clr = 1'b1; load = 1'b0; ent = 1'b0; enp = 1'b0; up = 1'b1; d = 4'd0;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    edge_wait();
    clr = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
      n_fail++;
      $display("FAIL reset: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
               q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
    end
    up = 1'b0;
    #1;
    n_tests++;
    if (tc !== 1'b1 || rco !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_down_tc: got tc=%b rco=%b, want tc=1 rco=0", tc, rco);
    end
    ent = 1'b1;
    #1;
    n_tests++;
    if (rco !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_down_rco: got rco=%b, want 1", rco);
    end
    edge_wait();
    // Keep the counter at 0 for the next test: clear again with counting disabled.
    clr = 1'b1; ent = 1'b0;
    edge_wait();
    clr = 1'b0;
  endtask

  task automatic test_decade_up();
    exp_t e;
    logic [3:0] eq;
    ent = 1'b1; enp = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      eq = 4'(i % 10);
      push(eq, (i >= 10), (eq == 4'd9), (eq == 4'd9));
      edge_wait();
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
        n_fail++;
        $display("FAIL decade_up[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                 i, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
    end
  endtask

  task automatic test_down_load();
    exp_t e;
    logic [3:0] eq;
    load = 1'b1; d = 4'd13; up = 1'b1; ent = 1'b1; enp = 1'b1;
    push(4'd9, 1'b0, 1'b1, 1'b1);
    edge_wait();
    load = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
      n_fail++;
      $display("FAIL load_clamp: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
               q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
    end
    up = 1'b0;
    for (int i = 1; i <= 10; i++) begin
`ifdef EM_COUNTER_SAT_EN
      eq = (i <= 9) ? 4'(9 - i) : 4'd0;
`else
      eq = (i <= 9) ? 4'(9 - i) : 4'd9;
`endif
      push(eq, (i == 10), (eq == 4'd0), (eq == 4'd0));
      edge_wait();
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
        n_fail++;
        $display("FAIL down[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                 i, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
    end
  endtask

  task automatic test_enables();
    exp_t e;
    up = 1'b1; load = 1'b1; d = 4'd5; ent = 1'b1; enp = 1'b0;
    push(4'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(4'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge_wait();
      load = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
        n_fail++;
        $display("FAIL enp_hold[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                 i, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
    end
    load = 1'b1; d = 4'd9; ent = 1'b0; enp = 1'b1;
    for (int i = 0; i < 3; i++) push(4'd9, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      load = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || wrap !== e.wrap || tc !== e.tc || rco !== e.rco) begin
        n_fail++;
        $display("FAIL ent_hold[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                 i, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    // Stimulus rows: clr, load, d, ent/enp (up stays 1).
    logic       r_clr [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       r_load[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] r_d   [7] = '{4'd7, 4'd3, 4'd3, 4'd3, 4'd9, 4'd0, 4'd2};
    logic       r_cnt [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    up = 1'b1;
    push(4'd7, 1'b0, 1'b0, 1'b0);   // plain load
    push(4'd0, 1'b0, 1'b0, 1'b0);   // clr beats load
    push(4'd0, 1'b0, 1'b0, 1'b0);   // clr held while counting
    push(4'd3, 1'b0, 1'b0, 1'b0);   // load beats count
    push(4'd9, 1'b0, 1'b0, 1'b0);   // load 9, counting off (ent=0 so rco=0)
    push(4'd0, 1'b1, 1'b0, 1'b0);   // 9 -> 0 wraps
    push(4'd2, 1'b0, 1'b0, 1'b0);   // load clears wrap while counting
    for (int i = 0; i < 7; i++) begin
      clr = r_clr[i]; load = r_load[i]; d = r_d[i]; ent = r_cnt[i]; enp = r_cnt[i];
      edge_wait();
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || wrap !== e.wrap || (i != 4 && tc !== e.tc) || (i != 4 && rco !== e.rco)) begin
        n_fail++;
        $display("FAIL priority[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                 i, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
    end
    clr = 1'b0; load = 1'b0; ent = 1'b0; enp = 1'b0;
  endtask

  task automatic test_cascade();
    cexp_t ce;
    logic [7:0] r_load_val[2] = '{8'h0F, 8'hFF};
    logic [7:0] r_exp     [2] = '{8'h10, 8'h00};
    logic       r_wrap    [2] = '{1'b0, 1'b1};
    c_clr = 1'b1; c_load = 1'b0; c_ent = 1'b1; c_enp = 1'b1; c_up = 1'b1;
    c_d_lo = 4'h0; c_d_hi = 4'h0;
    edge_wait();
    c_clr = 1'b0;
    n_tests++;
    if ({q_hi, q_lo} !== 8'h00 || wrap_lo !== 1'b0 || wrap_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade_reset: got q=%h wrap=%b%b, want q=00 wrap=00", {q_hi, q_lo}, wrap_hi, wrap_lo);
    end
    for (int i = 0; i < 2; i++) begin
      c_load = 1'b1; {c_d_hi, c_d_lo} = r_load_val[i];
      edge_wait();
      c_load = 1'b0;
      n_tests++;
      if ({q_hi, q_lo} !== r_load_val[i] || rco_lo !== 1'b1) begin
        n_fail++;
        $display("FAIL cascade_load[%0d]: got q=%h rco_lo=%b, want q=%h rco_lo=1",
                 i, {q_hi, q_lo}, rco_lo, r_load_val[i]);
      end
      ce.q = r_exp[i]; ce.wrap_lo = 1'b1; ce.wrap_hi = r_wrap[i];
      csb.push_back(ce);
      edge_wait();
      ce = csb.pop_front();
      n_tests++;
      if ({q_hi, q_lo} !== ce.q || wrap_lo !== ce.wrap_lo || wrap_hi !== ce.wrap_hi) begin
        n_fail++;
        $display("FAIL cascade_count[%0d]: got q=%h wrap_hi=%b wrap_lo=%b, want q=%h wrap_hi=%b wrap_lo=%b",
                 i, {q_hi, q_lo}, wrap_hi, wrap_lo, ce.q, ce.wrap_hi, ce.wrap_lo);
      end
    end
    c_ent = 1'b0;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; ent = 1'b0; enp = 1'b0; up = 1'b1; d = 4'd0;
    c_clr = 1'b1; c_load = 1'b0; c_ent = 1'b0; c_enp = 1'b0; c_up = 1'b1;
    c_d_lo = 4'd0; c_d_hi = 4'd0;
    #1;
    test_reset();
    test_decade_up();
    test_down_load();
    test_enables();
    test_priority();
    test_cascade();
    if (sb.size() != 0 || csb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", sb.size(), csb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/em_updown_counter.md
# em_updown_counter

Parametrised synchronous up/down counter: the next-generation replacement for the fixed 4-bit binary counter packages in the TTL emulation library. It generalises width and modulus (binary or decade/arbitrary), adds count direction, a terminal-count output, a sticky wrap flag and optional saturation. It is used for the program counter, memory-address and timing-chain counters in the EDUC-8 datapath, and cascades through `rco`/`ent` like the discrete parts.

## Interface
- `WIDTH`, 4, counter width in bits (1..16).
- `MODULUS`, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- `clk`  input  1  rising-edge clock; the only clock.
- `clr`  input  1  synchronous active-high reset/clear.
- `load`  input  1  synchronous parallel load, active-high.
- `ent`  input  1  count enable T; also gates `rco` (cascade input).
- `enp`  input  1  count enable P.
- `up`  input  1  direction: 1 = up, 0 = down.
- `d`  input  WIDTH  parallel load data.
- `q`  output  WIDTH  current count.
- `tc`  output  1  terminal count for the current direction (ungated).
- `rco`  output  1  ripple carry/borrow out, `tc & ent`.
- `wrap`  output  1  sticky flag, set when the counter wraps (or saturates).

One clock (`clk`), reset `clr` synchronous and active-high.

## Operation
- Priority at each rising edge: `clr` > `load` > count > hold.
- `clr`=1: `q`<=0 and `wrap`<=0.
- `load`=1: `q`<=`d` if `d` < MODULUS, otherwise `q`<=MODULUS-1 (clamped). `wrap`<=0. Enables and `up` are ignored.
- Count: when `ent`=1 and `enp`=1:
  - Up: `q`<=`q`+1, or 0 if `q`=MODULUS-1.
  - Down: `q`<=`q`-1, or MODULUS-1 if `q`=0.
  - On wrap, `wrap`<=1.
- Hold: if either enable is 0, `q` and `wrap` are unchanged.
- `tc` is combinational:
  - 1 when `up`=1 and `q`=MODULUS-1.
  - 1 when `up`=0 and `q`=0.
  - Independent of the enables.
- `rco` = `tc & ent`, combinational. `enp` does not affect `rco`.
- All arithmetic is on WIDTH bits. When MODULUS=2^WIDTH, the wrap compare is equivalent to natural overflow, but it must still be implemented by the MODULUS compare.
- Changing `up` takes effect on the next counting edge. `tc` and `rco` follow `up` immediately.

## Timing
- Reset values (after a `clr` edge): `q`=0, `wrap`=0. `tc` = ~`up` (because `q`=0), `rco` = ~`up` & `ent`.
- Before the first `clr` edge, outputs are undefined. The bench must apply `clr` for at least one edge.
- Latency: `q` and `wrap` update 1 cycle after the sampled edge. `tc` and `rco` have zero-cycle combinational latency from `q`, `up` and `ent`.
- Cascade: stage N+1 has `ent`=`rco` of stage N and shares `clk`, `enp`, `up` and `clr`. The chain advances as one wide counter with no extra latency.
- Reset mid-count or mid-load: `clr` wins on that edge and the load is discarded.
- `clr` held: `q` stays 0 and `wrap` stays 0 regardless of the other inputs.
- `load` and count on the same edge: load wins, and `wrap` is cleared even if the count would have wrapped.

## Configuration
- Macro `EM_COUNTER_SAT_EN`.
- Undefined (default): wrap-around behaviour as in Operation.
- Defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds at MODULUS-1; down at 0 holds at 0.
  - `wrap` is set on any attempted count past the limit.
  - `tc`/`rco` behaviour is unchanged.

## Test plan
- Reset: WIDTH=4, MODULUS=10, `up`=1, pulse `clr` for 1 edge -> `q`=0, `wrap`=0, `tc`=0. With `up`=0, `tc`=1; with `up`=0 and `ent`=1, `rco`=1.
- Decade up-count: MODULUS=10, `ent`=`enp`=1, `up`=1, 12 edges from 0 -> `q` = 1..9,0,1,2. `tc`/`rco` high only while `q`=9. `wrap`=1 from the edge where `q` goes 9->0.
- Down-count and load clamp: load `d`=13 -> `q`=9, `wrap`=0. Then `up`=0, 10 edges -> `q` = 8..0,9. With `EM_COUNTER_SAT_EN` defined, `q` holds at 0 and `wrap`=1 instead.
- Enables: `q`=5, `enp`=0, `ent`=1, 3 edges -> `q` stays 5. Then `q`=9 with `ent`=0 -> `tc`=1, `rco`=0, `q` holds.
- Priority: `q`=7 with `clr`=`load`=1, `d`=3 -> `q`=0. Then `load`=1, `d`=3, counting enabled -> `q`=3, not 4.
- Cascade: two WIDTH=4, MODULUS=16 stages chained, counting from 0x0F -> 0x10 on the next edge. From 0xFF up -> 0x00 with both stages' `wrap`=1.
